// File: rtl/ascensor_pkg.sv
// ---------------------------------------------------------------------------
// ascensor_pkg
// Shared definitions for the 4-floor elevator request scheduler:
//   - sequencer state encoding
//   - floor count and floor index width
//   - floor mask helpers used by the request decoder
// ---------------------------------------------------------------------------
package ascensor_pkg;

  localparam int N_PISOS = 4;
  localparam int PISO_W  = 2;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    MOVIENDO = 3'd1,
    PASO     = 3'd2,
    LLEGADA  = 3'd3,
    PUERTA   = 3'd4
  } estado_t;

  // One-hot mask selecting the given floor.
  function automatic logic [N_PISOS-1:0] piso_onehot(input logic [PISO_W-1:0] p);
    piso_onehot = 4'b0001 << p;
  endfunction

  // Mask of every floor strictly above p (wraps to zero at the top floor).
  function automatic logic [N_PISOS-1:0] mascara_arriba(input logic [PISO_W-1:0] p);
    mascara_arriba = ~((4'b0010 << p) - 4'b0001);
  endfunction

  // Mask of every floor strictly below p.
  function automatic logic [N_PISOS-1:0] mascara_abajo(input logic [PISO_W-1:0] p);
    mascara_abajo = (4'b0001 << p) - 4'b0001;
  endfunction

endpackage

// File: rtl/ascensor_pedidos.sv
// ---------------------------------------------------------------------------
// ascensor_pedidos
// Pending-request latch and position decode for the elevator sequencer.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   b_piso          hall call buttons (level)
//   ir_a_piso       cabin destination buttons (level)
//   piso            current floor
//   clr             serve the current floor this cycle (clear beats set)
//   ignorar         door open here: calls for the current floor are not latched
//   pendientes      latched pending requests
//   arriba/abajo    some request above / below the current floor
//   aqui            request latched for the current floor
//   req_aqui        a button for the current floor is pressed right now
// ---------------------------------------------------------------------------
module ascensor_pedidos
  import ascensor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PISOS-1:0] b_piso,
  input  logic [N_PISOS-1:0] ir_a_piso,
  input  logic [PISO_W-1:0]  piso,
  input  logic               clr,
  input  logic               ignorar,
  output logic [N_PISOS-1:0] pendientes,
  output logic               arriba,
  output logic               abajo,
  output logic               aqui,
  output logic               req_aqui
);

  logic [N_PISOS-1:0] pend_r;
  logic [N_PISOS-1:0] sol_s;
  logic [N_PISOS-1:0] actual_s;
  logic [N_PISOS-1:0] sol_ok_s;
  logic [N_PISOS-1:0] borrar_s;

  // Merge button sources and build the set/clear masks for this cycle.
  always_comb begin
    sol_s    = b_piso | ir_a_piso;
    actual_s = piso_onehot(piso);
    if (ignorar) begin
      sol_ok_s = sol_s & ~actual_s;
    end else begin
      sol_ok_s = sol_s;
    end
    if (clr) begin
      borrar_s = actual_s;
    end else begin
      borrar_s = 4'b0000;
    end
  end

  // Pending-request register; a clear on the same bit wins over a new set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= 4'b0000;
    end else begin
      pend_r <= (pend_r | sol_ok_s) & ~borrar_s;
    end
  end

  assign pendientes = pend_r;
  assign arriba     = |(pend_r & mascara_arriba(piso));
  assign abajo      = |(pend_r & mascara_abajo(piso));
  assign aqui       = |(pend_r & actual_s);
  assign req_aqui   = |(sol_s & actual_s);

endmodule

// File: rtl/ascensor_control.sv
// ---------------------------------------------------------------------------
// ascensor_control
// SCAN request scheduler and motion sequencer for a 4-floor elevator. Drives
// the downstream floor FSM (sube/baja/en) and reads back its floor (piso).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   b_piso          hall call buttons, bit i = floor i
//   ir_a_piso       cabin destination buttons, bit i = floor i
//   piso            current floor from the floor FSM
//   sube / baja     one-cycle move pulses (never both high)
//   en              sube | baja
//   puerta_abierta  door open
//   dir_sube        travel direction, 1 = up
//   pendientes      latched pending requests
//   ocupado         sequencer not idle
// ---------------------------------------------------------------------------
module ascensor_control
  import ascensor_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 100,
  parameter int DOOR_CYCLES   = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PISOS-1:0] b_piso,
  input  logic [N_PISOS-1:0] ir_a_piso,
  input  logic [PISO_W-1:0]  piso,
  output logic               sube,
  output logic               baja,
  output logic               en,
  output logic               puerta_abierta,
  output logic               dir_sube,
  output logic [N_PISOS-1:0] pendientes,
  output logic               ocupado
);

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] FIN_VIAJE  = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] FIN_PUERTA = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] UNO        = TW'(1);
  localparam logic [TW-1:0] CERO       = TW'(0);

  estado_t       state_r;
  logic [TW-1:0] timer_r;
  logic          dir_sube_r;
  logic          sube_r;
  logic          baja_r;
  logic          en_r;
  logic          puerta_r;
  logic          ocupado_r;

  logic          arriba_s;
  logic          abajo_s;
  logic          aqui_s;
  logic          req_aqui_s;
  logic          clr_s;
  logic          ignorar_s;
  logic          adelante_s;

  // A floor is served only where the sequencer takes the stop decision.
  assign clr_s      = ((state_r == REPOSO) || (state_r == LLEGADA)) && aqui_s;
  assign ignorar_s  = (state_r == PUERTA);
  assign adelante_s = dir_sube_r ? arriba_s : abajo_s;

  ascensor_pedidos u_pedidos (
    .clk        (clk),
    .rst        (rst),
    .b_piso     (b_piso),
    .ir_a_piso  (ir_a_piso),
    .piso       (piso),
    .clr        (clr_s),
    .ignorar    (ignorar_s),
    .pendientes (pendientes),
    .arriba     (arriba_s),
    .abajo      (abajo_s),
    .aqui       (aqui_s),
    .req_aqui   (req_aqui_s)
  );

  // Sequencer FSM; outputs are registered from the state being entered so
  // that the move pulses are glitch-free and exactly one PASO cycle long.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= REPOSO;
      timer_r    <= CERO;
      dir_sube_r <= 1'b1;
      sube_r     <= 1'b0;
      baja_r     <= 1'b0;
      en_r       <= 1'b0;
      puerta_r   <= 1'b0;
      ocupado_r  <= 1'b0;
    end else begin
      sube_r <= 1'b0;
      baja_r <= 1'b0;
      en_r   <= 1'b0;
      case (state_r)
        REPOSO: begin
          if (aqui_s) begin
            timer_r   <= CERO;
            state_r   <= PUERTA;
            puerta_r  <= 1'b1;
            ocupado_r <= 1'b1;
          end else if (arriba_s && (dir_sube_r || !abajo_s)) begin
            dir_sube_r <= 1'b1;
            timer_r    <= CERO;
            state_r    <= MOVIENDO;
            ocupado_r  <= 1'b1;
          end else if (abajo_s) begin
            dir_sube_r <= 1'b0;
            timer_r    <= CERO;
            state_r    <= MOVIENDO;
            ocupado_r  <= 1'b1;
          end else begin
            ocupado_r <= 1'b0;
          end
        end
        MOVIENDO: begin
          if (timer_r == FIN_VIAJE) begin
            timer_r <= CERO;
            state_r <= PASO;
            sube_r  <= dir_sube_r;
            baja_r  <= !dir_sube_r;
            en_r    <= 1'b1;
          end else begin
            timer_r <= timer_r + UNO;
          end
        end
        PASO: begin
          state_r <= LLEGADA;
        end
        LLEGADA: begin
          // piso already shows the floor just reached.
          if (aqui_s) begin
            timer_r  <= CERO;
            state_r  <= PUERTA;
            puerta_r <= 1'b1;
          end else if (adelante_s) begin
            timer_r <= CERO;
            state_r <= MOVIENDO;
          end else begin
            state_r   <= REPOSO;
            ocupado_r <= 1'b0;
          end
        end
        PUERTA: begin
          // A call for this floor while open keeps the door open longer.
          if (req_aqui_s) begin
            timer_r <= CERO;
          end else if (timer_r == FIN_PUERTA) begin
            timer_r   <= CERO;
            state_r   <= REPOSO;
            puerta_r  <= 1'b0;
            ocupado_r <= 1'b0;
          end else begin
            timer_r <= timer_r + UNO;
          end
        end
        default: begin
          state_r   <= REPOSO;
          timer_r   <= CERO;
          puerta_r  <= 1'b0;
          ocupado_r <= 1'b0;
        end
      endcase
    end
  end

  assign sube           = sube_r;
  assign baja           = baja_r;
  assign en             = en_r;
  assign puerta_abierta = puerta_r;
  assign dir_sube       = dir_sube_r;
  assign ocupado        = ocupado_r;

endmodule

// File: tb/tb_ascensor_control.sv
// ---------------------------------------------------------------------------
// tb_ascensor_control
// Closed-loop bench: ascensor_control driving a behavioural floor FSM.
// A procedural timeline model of the elevator predicts every output each
// cycle; directed scenarios add literal expectations; random traffic follows.
// ---------------------------------------------------------------------------
module tb_ascensor_control;

  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b_piso;
  logic [3:0] ir_a_piso;
  logic [1:0] piso;
  logic       sube, baja, en, puerta_abierta, dir_sube, ocupado;
  logic [3:0] pendientes;

  always #5 clk = ~clk;

  ascensor_control #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk), .rst(rst), .b_piso(b_piso), .ir_a_piso(ir_a_piso), .piso(piso),
    .sube(sube), .baja(baja), .en(en), .puerta_abierta(puerta_abierta),
    .dir_sube(dir_sube), .pendientes(pendientes), .ocupado(ocupado)
  );

  // Downstream floor FSM: one floor per en pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) piso <= 2'd0;
    else if (en) piso <= sube ? piso + 2'd1 : piso - 2'd1;
  end

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [3:0] m_pend;
  int         m_piso;
  logic       m_dir;
  logic       m_abort;
  logic       m_live;
  logic       exp_sube, exp_baja, exp_door, exp_ocup, exp_dir;
  logic [3:0] exp_pend;
  int         exp_piso;

  // Monitor state
  int cyc = 0, n_sube = 0, n_baja = 0, n_door_cyc = 0, n_door_open = 0;
  int last_sube = 0, sube_gap = 0;
  logic prev_dir = 1'b1, prev_ocup = 1'b0, prev_door = 1'b0;
  int door_floors[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pend_above();
    for (int i = m_piso + 1; i < 4; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic pend_below();
    for (int i = 0; i < m_piso; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] here_mask();
    logic [3:0] v;
    v = 4'b0001 << m_piso;
    return v;
  endfunction

  // Publish what the outputs must be during the cycle now starting.
  task automatic show(input logic busy, input logic door, input logic s, input logic b);
    exp_ocup = busy; exp_door = door; exp_sube = s; exp_baja = b;
    exp_dir  = m_dir; exp_pend = m_pend; exp_piso = m_piso;
  endtask

  // Advance one clock: latch buttons into the model's request set.
  task automatic step(input logic [3:0] clr, input logic [3:0] blk, output logic here);
    logic [3:0] req;
    @(posedge clk or negedge rst);
    if (rst !== 1'b1) begin
      m_abort = 1'b1;
      here = 1'b0;
    end else begin
      req    = b_piso | ir_a_piso;
      here   = req[m_piso];
      m_pend = (m_pend | (req & ~blk)) & ~clr;
    end
  endtask

  task automatic door();
    logic h;
    int left = DOOR;
    forever begin
      show(1'b1, 1'b1, 1'b0, 1'b0);
      step(4'b0000, here_mask(), h);
      if (m_abort) return;
      if (h) left = DOOR;
      else left--;
      if (left == 0) return;
    end
  endtask

  task automatic travel();
    logic h;
    forever begin
      for (int k = 0; k < TRAVEL; k++) begin
        show(1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, h);
        if (m_abort) return;
      end
      show(1'b1, 1'b0, m_dir, ~m_dir);
      step(4'b0000, 4'b0000, h);
      if (m_abort) return;
      m_piso = m_dir ? m_piso + 1 : m_piso - 1;
      show(1'b1, 1'b0, 1'b0, 1'b0);
      if (m_pend[m_piso]) begin
        step(here_mask(), 4'b0000, h);
        if (!m_abort) door();
        return;
      end else if (m_dir ? pend_above() : pend_below()) begin
        step(4'b0000, 4'b0000, h);
        if (m_abort) return;
      end else begin
        step(4'b0000, 4'b0000, h);
        return;
      end
    end
  endtask

  task automatic model_loop();
    logic h;
    forever begin
      if (m_abort || rst !== 1'b1) begin
        m_live = 1'b0; m_pend = 4'b0000; m_piso = 0; m_dir = 1'b1; m_abort = 1'b0;
        wait (rst === 1'b1);
        m_live = 1'b1;
      end
      show(1'b0, 1'b0, 1'b0, 1'b0);
      if (m_pend[m_piso]) begin
        step(here_mask(), 4'b0000, h);
        if (!m_abort) door();
      end else if (pend_above() && (m_dir || !pend_below())) begin
        m_dir = 1'b1;
        step(4'b0000, 4'b0000, h);
        if (!m_abort) travel();
      end else if (pend_below()) begin
        m_dir = 1'b0;
        step(4'b0000, 4'b0000, h);
        if (!m_abort) travel();
      end else begin
        step(4'b0000, 4'b0000, h);
      end
    end
  endtask

  task automatic compare_cycle();
    if (rst !== 1'b1 || m_live !== 1'b1) begin
      prev_dir = 1'b1; prev_ocup = 1'b0; prev_door = 1'b0;
    end else begin
      cyc++;
      check("sube", sube, exp_sube);
      check("baja", baja, exp_baja);
      check("en", en, exp_sube | exp_baja);
      check("puerta_abierta", puerta_abierta, exp_door);
      check("dir_sube", dir_sube, exp_dir);
      check("pendientes", pendientes, exp_pend);
      check("ocupado", ocupado, exp_ocup);
      check("piso", piso, exp_piso);
      check("sube_en_piso3", sube && (piso == 2'd3), 1'b0);
      check("baja_en_piso0", baja && (piso == 2'd0), 1'b0);
      check("en_decode", en, sube | baja);
      check("pulso_con_puerta", (sube | baja) & puerta_abierta, 1'b0);
      if (sube) begin n_sube++; sube_gap = cyc - last_sube; last_sube = cyc; end
      if (baja) n_baja++;
      if (puerta_abierta) n_door_cyc++;
      if (puerta_abierta && !prev_door) begin n_door_open++; door_floors.push_back(int'(piso)); end
      if (dir_sube !== prev_dir) check("dir_cambia_en_reposo", prev_ocup, 1'b0);
      prev_dir = dir_sube; prev_ocup = ocupado; prev_door = puerta_abierta;
    end
  endtask

  task automatic press(input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    b_piso = b; ir_a_piso = c;
    @(negedge clk);
    b_piso = 4'b0000; ir_a_piso = 4'b0000;
  endtask

  task automatic wait_idle(input string name, input int bound);
    logic ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (!ocupado && pendientes == 4'b0000) ok = 1'b1;
    end
    check(name, ok, 1'b1);
  endtask

  task automatic wait_piso(input string name, input logic [1:0] p, input int bound);
    logic ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (piso == p) ok = 1'b1;
    end
    check(name, ok, 1'b1);
  endtask

  function automatic int floor_at(input int idx);
    if (idx < door_floors.size()) return door_floors[idx];
    return 99;
  endfunction

  int s_sube, s_baja, s_dc, s_do, idx;

  initial begin
    rst = 1'b0; b_piso = 4'b0000; ir_a_piso = 4'b0000; m_abort = 1'b1; m_live = 1'b0;
    fork
      model_loop();
      forever begin @(negedge clk); compare_cycle(); end
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_pendientes", pendientes, 4'b0000);
    check("rst_dir_sube", dir_sube, 1'b1);
    check("rst_sube", sube, 1'b0);
    check("rst_puerta", puerta_abierta, 1'b0);
    check("rst_ocupado", ocupado, 1'b0);
    check("rst_piso", piso, 2'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Single trip 0 -> 2
    repeat (2) @(negedge clk);
    s_sube = n_sube; s_dc = n_door_cyc;
    press(4'b0000, 4'b0100);
    wait_idle("espera_viaje_2", 200);
    check("t2_num_sube", n_sube - s_sube, 2);
    check("t2_separacion", sube_gap, 6);
    check("t2_piso", piso, 2'd2);
    check("t2_modelo_piso", m_piso, 2);
    check("t2_ciclos_puerta", n_door_cyc - s_dc, 3);
    check("t2_pendientes", pendientes, 4'b0000);
    check("t2_ocupado", ocupado, 1'b0);

    // SCAN order: go to 0, then request 3; call 0 once the car reaches floor 1
    press(4'b0000, 4'b0001);
    wait_idle("espera_vuelta_0", 200);
    s_sube = n_sube; s_baja = n_baja; idx = door_floors.size();
    press(4'b0000, 4'b1000);
    wait_piso("espera_piso1", 1, 100);
    b_piso = 4'b0001;
    @(negedge clk);
    b_piso = 4'b0000;
    wait_idle("espera_scan", 400);
    check("scan_num_sube", n_sube - s_sube, 3);
    check("scan_num_baja", n_baja - s_baja, 3);
    check("scan_paradas", door_floors.size() - idx, 2);
    check("scan_primera", floor_at(idx), 3);
    check("scan_segunda", floor_at(idx + 1), 0);

    // Door hold at floor 2: call floor 2 again in the last door cycle
    press(4'b0000, 4'b0100);
    s_dc = n_door_cyc; s_do = n_door_open;
    begin
      logic ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        if (puerta_abierta) ok = 1'b1;
      end
      check("espera_puerta", ok, 1'b1);
    end
    repeat (2) @(negedge clk);
    b_piso = 4'b0100;
    @(negedge clk);
    b_piso = 4'b0000;
    check("hold_pend2", pendientes[2], 1'b0);
    wait_idle("espera_hold", 100);
    check("hold_ciclos_puerta", n_door_cyc - s_dc, 6);
    check("hold_aperturas", n_door_open - s_do, 1);

    // Hall call at floor 1 arriving in the arrival cycle
    s_dc = n_door_cyc; s_do = n_door_open; s_baja = n_baja;
    press(4'b0000, 4'b0010);
    wait_piso("espera_llegada1", 1, 100);
    b_piso = 4'b0010;
    @(negedge clk);
    b_piso = 4'b0000;
    wait_idle("espera_simul", 100);
    check("simul_aperturas", n_door_open - s_do, 1);
    check("simul_ciclos_puerta", n_door_cyc - s_dc, 3);
    check("simul_baja", n_baja - s_baja, 1);
    check("simul_pendientes", pendientes, 4'b0000);

    // Reset in the middle of a move
    s_sube = n_sube;
    press(4'b0000, 4'b1000);
    repeat (2) @(negedge clk);
    check("mid_ocupado", ocupado, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_pendientes", pendientes, 4'b0000);
    check("mid_rst_sube", sube, 1'b0);
    check("mid_rst_en", en, 1'b0);
    check("mid_rst_dir", dir_sube, 1'b1);
    check("mid_rst_ocupado", ocupado, 1'b0);
    check("mid_rst_piso", piso, 2'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_sin_pulso", n_sube - s_sube, 0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_post_piso", piso, 2'd0);

    // Random traffic, then drain: every latched request must be served
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      b_piso    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      ir_a_piso = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
    end
    @(negedge clk);
    b_piso = 4'b0000; ir_a_piso = 4'b0000;
    wait_idle("drenaje", 3000);
    check("final_pendientes", pendientes, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
